// File: rtl/segm_pkg.sv
// Shared segment glyphs, conversion FSM states and small constant helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package segm_pkg;

    // Active-high glyph patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

    // Active-high glyph for one BCD nibble; codes 10..15 are not valid BCD and show a dash
    function automatic logic [6:0] seg_glyph(input logic [3:0] nibble);
        logic [6:0] g;
        case (nibble)
            4'd0:    g = 7'b0111111;
            4'd1:    g = 7'b0000110;
            4'd2:    g = 7'b1011011;
            4'd3:    g = 7'b1001111;
            4'd4:    g = 7'b1100110;
            4'd5:    g = 7'b1101101;
            4'd6:    g = 7'b1111101;
            4'd7:    g = 7'b0000111;
            4'd8:    g = 7'b1111111;
            4'd9:    g = 7'b1101111;
            default: g = SEG_DASH;
        endcase
        return g;
    endfunction

    // 10**n as a 64-bit constant, used for the overflow threshold
    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with capture/hold control.
// Latency: IN_W+1 cycles from capture edge to valid_o; a new capture every IN_W+2 cycles.
// Backpressure: none; hold_i only suppresses new captures, an in-flight conversion always completes.
module bin2bcd_seq
    import segm_pkg::*;
#(
    parameter int IN_W   = 4,
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IN_W-1:0]     bin_i,
    input  logic                hold_i,
    output logic [4*DIGITS-1:0] bcd_o,
    output logic                ovf_o,
    output logic                valid_o
);

    localparam int          BCD_W = 4 * DIGITS;
    localparam int          CNT_W = $clog2(IN_W + 1);
    localparam logic [63:0] LIMIT = pow10(DIGITS);

    conv_state_t      state;
    logic [IN_W-1:0]  bin_sr;
    logic [BCD_W-1:0] bcd_sr;
    logic [BCD_W-1:0] bcd_adj;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt;

    // Add-3 correction on every nibble of 5 or more, ahead of the shift
    always_comb begin
        bcd_adj = bcd_sr;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_sr[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_sr[4*k +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM: capture in IDLE, IN_W shift steps, publish result in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bin_sr  <= '0;
            bcd_sr  <= '0;
            ovf_q   <= 1'b0;
            cnt     <= '0;
            bcd_o   <= '0;
            ovf_o   <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (!hold_i) begin
                        bin_sr <= bin_i;
                        ovf_q  <= (64'(bin_i) >= LIMIT);
                        bcd_sr <= '0;
                        cnt    <= CNT_W'(IN_W);
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Bits shifted out of the top nibble are dropped; lower digits stay exact
                    bcd_sr <= {bcd_adj[BCD_W-2:0], bin_sr[IN_W-1]};
                    bin_sr <= {bin_sr[IN_W-2:0], 1'b0};
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd_o   <= bcd_sr;
                    ovf_o   <= ovf_q;
                    valid_o <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/gray_seg_scan.sv
// Gray-coded input to multiplexed common-anode 7-segment display with BCD conversion.
// Latency: IN_W+1 cycles capture-to-valid, display follows bcd_o one cycle later.
// Backpressure: none; scanner free-runs, hold_i freezes the displayed value.
module gray_seg_scan
    import segm_pkg::*;
#(
    parameter int IN_W           = 4,
    parameter int DIGITS         = 2,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IN_W-1:0]     gray_i,
    input  logic                hold_i,
    input  logic                blank_i,
    output logic [6:0]          seg_o,
    output logic [DIGITS-1:0]   an_o,
    output logic [4*DIGITS-1:0] bcd_o,
    output logic                valid_o,
    output logic                ovf_o
);

    localparam int         RC_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int         IX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [6:0] SEG_RST = (SEG_ACTIVE_LOW != 0) ? ~seg_glyph(4'd0) : seg_glyph(4'd0);

    function automatic logic [IN_W-1:0] gray2bin(input logic [IN_W-1:0] g);
        logic [IN_W-1:0] b;
        b[IN_W-1] = g[IN_W-1];
        for (int i = IN_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [IN_W-1:0]   bin;
    logic [RC_W-1:0]   rcnt;
    logic [IX_W-1:0]   idx;
    logic [IX_W-1:0]   idx_nxt;
    logic              rc_tc;
    logic [DIGITS-1:0] lz;
    logic [3:0]        nib;
    logic              blank_dig;
    logic [6:0]        glyph_nxt;

    assign bin = gray2bin(gray_i);

    bin2bcd_seq #(
        .IN_W   (IN_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .bin_i   (bin),
        .hold_i  (hold_i),
        .bcd_o   (bcd_o),
        .ovf_o   (ovf_o),
        .valid_o (valid_o)
    );

    // Next digit index: advance on the refresh terminal count
    always_comb begin
        rc_tc   = (rcnt == RC_W'(REFRESH_DIV - 1));
        idx_nxt = idx;
        if (rc_tc) begin
            idx_nxt = (idx == IX_W'(DIGITS - 1)) ? '0 : idx + IX_W'(1);
        end
    end

    // lz[k]: digits k..DIGITS-1 are all zero
    always_comb begin
        lz = '0;
        lz[DIGITS-1] = (bcd_o[4*(DIGITS-1) +: 4] == 4'd0);
        for (int k = DIGITS - 2; k >= 0; k--) begin
            lz[k] = lz[k+1] && (bcd_o[4*k +: 4] == 4'd0);
        end
    end

    // Glyph for the digit about to be enabled: overflow dash beats blanking
    always_comb begin
        nib       = 4'd0;
        blank_dig = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_nxt == IX_W'(k)) begin
                nib       = bcd_o[4*k +: 4];
                blank_dig = (k != 0) && lz[k];
            end
        end
        if (ovf_o) begin
            glyph_nxt = SEG_DASH;
        end else if (blank_i && blank_dig) begin
            glyph_nxt = SEG_BLANK;
        end else begin
            glyph_nxt = seg_glyph(nib);
        end
    end

    // Refresh scanner: anode and segments register on the same edge so they never skew
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt  <= '0;
            idx   <= '0;
            an_o  <= ~DIGITS'(1);
            seg_o <= SEG_RST;
        end else begin
            rcnt  <= rc_tc ? '0 : rcnt + RC_W'(1);
            idx   <= idx_nxt;
            an_o  <= ~(DIGITS'(1) << idx_nxt);
            seg_o <= (SEG_ACTIVE_LOW != 0) ? ~glyph_nxt : glyph_nxt;
        end
    end

endmodule

// File: tb/tb_gray_seg_scan.sv
// Scoreboard bench for gray_seg_scan: a 4-bit and an 8-bit instance share clock and reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_gray_seg_scan;

    typedef struct packed {
        logic [7:0] bcd;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] gray4;
    logic       hold4, blank4, valid4, ovf4;
    logic [6:0] seg4;
    logic [1:0] an4;
    logic [7:0] bcd4;
    logic [7:0] gray8;
    logic       hold8, blank8, valid8, ovf8;
    logic [6:0] seg8;
    logic [1:0] an8;
    logic [7:0] bcd8;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    // Active-low glyphs 0..9, written out independently of the RTL table
    logic [6:0] low_glyph [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                   7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    gray_seg_scan #(.IN_W(4), .DIGITS(2), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .gray_i(gray4), .hold_i(hold4), .blank_i(blank4),
        .seg_o(seg4), .an_o(an4), .bcd_o(bcd4), .valid_o(valid4), .ovf_o(ovf4)
    );

    gray_seg_scan #(.IN_W(8), .DIGITS(2), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .gray_i(gray8), .hold_i(hold8), .blank_i(blank8),
        .seg_o(seg8), .an_o(an8), .bcd_o(bcd8), .valid_o(valid8), .ovf_o(ovf8)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_gray(input int v);
        logic [7:0] b;
        b = 8'(v);
        return b ^ (b >> 1);
    endfunction

    function automatic exp_t model(input int v);
        exp_t e;
        e.bcd = {4'((v / 10) % 10), 4'(v % 10)};
        e.ovf = (v >= 100);
        return e;
    endfunction

    task automatic wait_valid(input int which, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if ((which == 0) ? valid4 : valid8) begin
                cyc = n;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_digit(input int which, input int d, output logic [6:0] s, output bit ok);
        logic [1:0] target;
        target = ~(2'b01 << d);
        ok = 1'b0;
        s  = 7'bx;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (((which == 0) ? an4 : an8) == target) begin
                s  = (which == 0) ? seg4 : seg8;
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Park the FSM with hold, load a value, push its expectation, release for one conversion
    task automatic run_conv(input int which, input int v, output exp_t got, output bit ok);
        int cyc;
        if (which == 0) hold4 = 1'b1; else hold8 = 1'b1;
        repeat (12) @(negedge clk);
        if (which == 0) gray4 = 4'(to_gray(v)); else gray8 = to_gray(v);
        sb.push_back(model(v));
        if (which == 0) hold4 = 1'b0; else hold8 = 1'b0;
        wait_valid(which, cyc, ok);
        if (which == 0) hold4 = 1'b1; else hold8 = 1'b1;
        got.bcd = (which == 0) ? bcd4 : bcd8;
        got.ovf = (which == 0) ? ovf4 : ovf8;
    endtask

    task automatic test_reset;
        int   cyc;
        bit   ok;
        exp_t e;
        rst_n = 1'b0; gray4 = 4'b1000; hold4 = 1'b0; blank4 = 1'b0;
        gray8 = 8'h00; hold8 = 1'b1; blank8 = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bcd4, valid4, ovf4, an4, seg4} !== {8'h00, 1'b0, 1'b0, 2'b10, 7'b1000000}) begin
            miscompares++;
            $display("FAIL reset_state got bcd=%h v=%b o=%b an=%b seg=%b want 00 0 0 10 1000000",
                     bcd4, valid4, ovf4, an4, seg4);
        end
        sb.push_back(model(15));
        rst_n = 1'b1;
        wait_valid(0, cyc, ok);
        hold4 = 1'b1;
        // First edge after release captures; valid is visible IN_W+1 edges later
        vectors++;
        if (!ok || cyc != 6) begin
            miscompares++;
            $display("FAIL first_latency got %0d (ok=%0d) want 6", cyc, ok);
        end
        vectors++;
        e = sb.pop_front();
        if ({bcd4, ovf4} !== {e.bcd, e.ovf}) begin
            miscompares++;
            $display("FAIL first_result got %h/%b want %h/%b", bcd4, ovf4, e.bcd, e.ovf);
        end
    endtask

    task automatic test_sweep;
        exp_t       got, e;
        bit         ok;
        logic [6:0] s;
        for (int v = 0; v < 16; v++) begin
            run_conv(0, v, got, ok);
            e = sb.pop_front();
            vectors++;
            if (!ok || got !== e) begin
                miscompares++;
                $display("FAIL sweep_bcd v=%0d got %h/%b ok=%0d want %h/%b", v, got.bcd, got.ovf, ok, e.bcd, e.ovf);
            end
            repeat (2) @(negedge clk);
            wait_digit(0, 0, s, ok);
            vectors++;
            if (!ok || s !== low_glyph[v % 10]) begin
                miscompares++;
                $display("FAIL sweep_dig0 v=%0d got %b want %b", v, s, low_glyph[v % 10]);
            end
            wait_digit(0, 1, s, ok);
            vectors++;
            if (!ok || s !== low_glyph[v / 10]) begin
                miscompares++;
                $display("FAIL sweep_dig1 v=%0d got %b want %b", v, s, low_glyph[v / 10]);
            end
        end
    endtask

    task automatic test_scan;
        exp_t       got, e;
        bit         ok, found;
        logic [1:0] prev, want_an;
        logic [6:0] want_seg;
        run_conv(0, 12, got, ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || got !== e) begin
            miscompares++;
            $display("FAIL scan_bcd got %h ok=%0d want %h", got.bcd, ok, e.bcd);
        end
        repeat (2) @(negedge clk);
        prev  = an4;
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (an4 == 2'b10 && prev == 2'b01) begin
                found = 1'b1;
                break;
            end
            prev = an4;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL scan_wrap got no 01->10 anode step want one within 20 cycles");
        end
        if (found) begin
            for (int n = 0; n < 8; n++) begin
                if (n > 0) @(negedge clk);
                want_an  = (n < 4) ? 2'b10 : 2'b01;
                want_seg = (n < 4) ? 7'b0100100 : 7'b1111001;
                vectors++;
                if ({an4, seg4} !== {want_an, want_seg}) begin
                    miscompares++;
                    $display("FAIL scan_step%0d got an=%b seg=%b want an=%b seg=%b", n, an4, seg4, want_an, want_seg);
                end
            end
        end
    endtask

    task automatic test_overflow;
        exp_t       got, e;
        bit         ok;
        logic [6:0] s;
        run_conv(1, 100, got, ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || got !== e) begin
            miscompares++;
            $display("FAIL ovf_100 got %h/%b ok=%0d want %h/%b", got.bcd, got.ovf, ok, e.bcd, e.ovf);
        end
        blank8 = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            wait_digit(1, d, s, ok);
            vectors++;
            if (!ok || s !== 7'b0111111) begin
                miscompares++;
                $display("FAIL ovf_dash%0d got %b want 0111111", d, s);
            end
        end
        blank8 = 1'b0;
        run_conv(1, 50, got, ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || got !== e) begin
            miscompares++;
            $display("FAIL ovf_50 got %h/%b ok=%0d want %h/%b", got.bcd, got.ovf, ok, e.bcd, e.ovf);
        end
    endtask

    task automatic test_blank;
        exp_t       got, e;
        bit         ok;
        logic [6:0] s;
        blank4 = 1'b1;
        run_conv(0, 7, got, ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || got !== e) begin
            miscompares++;
            $display("FAIL blank_bcd got %h ok=%0d want %h", got.bcd, ok, e.bcd);
        end
        repeat (2) @(negedge clk);
        wait_digit(0, 1, s, ok);
        vectors++;
        if (!ok || s !== 7'b1111111) begin
            miscompares++;
            $display("FAIL blank_dig1 got %b want 1111111", s);
        end
        wait_digit(0, 0, s, ok);
        vectors++;
        if (!ok || s !== 7'b1111000) begin
            miscompares++;
            $display("FAIL blank_dig0 got %b want 1111000", s);
        end
        blank4 = 1'b0;
        repeat (2) @(negedge clk);
        wait_digit(0, 1, s, ok);
        vectors++;
        if (!ok || s !== 7'b1000000) begin
            miscompares++;
            $display("FAIL noblank_dig1 got %b want 1000000", s);
        end
    endtask

    task automatic test_back_to_back;
        int   cyc;
        bit   ok;
        exp_t e;
        hold4 = 1'b1;
        repeat (12) @(negedge clk);
        gray4 = 4'(to_gray(5));
        sb.push_back(model(5));
        sb.push_back(model(5));
        hold4 = 1'b0;
        wait_valid(0, cyc, ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || {bcd4, ovf4} !== {e.bcd, e.ovf}) begin
            miscompares++;
            $display("FAIL b2b_first got %h ok=%0d want %h", bcd4, ok, e.bcd);
        end
        wait_valid(0, cyc, ok);
        hold4 = 1'b1;
        vectors++;
        if (!ok || cyc != 6) begin
            miscompares++;
            $display("FAIL b2b_period got %0d ok=%0d want 6", cyc, ok);
        end
        e = sb.pop_front();
        vectors++;
        if ({bcd4, ovf4} !== {e.bcd, e.ovf}) begin
            miscompares++;
            $display("FAIL b2b_second got %h want %h", bcd4, e.bcd);
        end
    endtask

    task automatic test_hold;
        int         cyc, nvalid;
        bit         ok;
        exp_t       e;
        logic [7:0] frozen;
        hold4 = 1'b1;
        repeat (12) @(negedge clk);
        frozen = bcd4;
        gray4  = 4'(to_gray(3));
        nvalid = 0;
        repeat (20) begin
            @(negedge clk);
            if (valid4) nvalid++;
        end
        vectors++;
        if (nvalid != 0 || bcd4 !== frozen) begin
            miscompares++;
            $display("FAIL hold_freeze got bcd=%h valids=%0d want bcd=%h valids=0", bcd4, nvalid, frozen);
        end
        // Hold raised mid-conversion: the conversion in flight still lands
        gray4 = 4'(to_gray(9));
        sb.push_back(model(9));
        hold4 = 1'b0;
        repeat (2) @(negedge clk);
        hold4 = 1'b1;
        wait_valid(0, cyc, ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || {bcd4, ovf4} !== {e.bcd, e.ovf}) begin
            miscompares++;
            $display("FAIL hold_midconv got %h ok=%0d want %h", bcd4, ok, e.bcd);
        end
        nvalid = 0;
        repeat (20) begin
            @(negedge clk);
            if (valid4) nvalid++;
        end
        vectors++;
        if (nvalid != 0) begin
            miscompares++;
            $display("FAIL hold_after got %0d valids want 0", nvalid);
        end
    endtask

    task automatic test_reset_mid;
        int nvalid;
        gray4 = 4'(to_gray(14));
        hold4 = 1'b0;
        repeat (3) @(negedge clk);
        hold4 = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bcd4, valid4, ovf4, an4, seg4} !== {8'h00, 1'b0, 1'b0, 2'b10, 7'b1000000}) begin
            miscompares++;
            $display("FAIL rst_mid_state got bcd=%h v=%b o=%b an=%b seg=%b want 00 0 0 10 1000000",
                     bcd4, valid4, ovf4, an4, seg4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        nvalid = 0;
        repeat (20) begin
            @(negedge clk);
            if (valid4) nvalid++;
        end
        vectors++;
        if (nvalid != 0 || bcd4 !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_mid_after got valids=%0d bcd=%h want 0 and 00", nvalid, bcd4);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_scan();
        test_overflow();
        test_blank();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
